// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues two-instruction ICache requests, tracks one outstanding
// request, and redirects on predicted branches, delay-slot fetches and flushes.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        buffer_full_i,
    input  logic        bpu_taken_i,
    input  logic        bpu_select_i,
    input  logic [31:0] bpu_target_i,
    output logic        icache_req_o,
    output logic [31:0] icache_addr_o,
    input  logic        icache_addr_ok_i,
    input  logic        icache_data_ok_i,
    input  logic [31:0] icache_inst1_i,
    input  logic [31:0] icache_inst2_i,
    output logic [31:0] ib_inst1_o,
    output logic [31:0] ib_inst2_o,
    output logic [31:0] ib_inst1_addr_o,
    output logic [31:0] ib_inst2_addr_o,
    output logic        ib_inst1_valid_o,
    output logic        ib_inst2_valid_o,
    output logic        only_delayslot_inst_o
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        slot_pending_q, slot_pending_d;
    logic [31:0] target_q, target_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        req_slot_q, req_slot_d;

    logic accept;
    logic write;
    logic keep;

    always_comb begin
        icache_req_o  = !rst && (state_q == S_REQ) && !buffer_full_i;
        icache_addr_o = pc_q;
        accept        = icache_req_o && icache_addr_ok_i;
        write         = !rst && (state_q == S_WAIT) && icache_data_ok_i;
        keep          = write && !flush_i;
    end

    always_comb begin
        ib_inst1_o            = write ? icache_inst1_i : 32'd0;
        ib_inst2_o            = write ? icache_inst2_i : 32'd0;
        ib_inst1_addr_o       = write ? req_pc_q : 32'd0;
        ib_inst2_addr_o       = write ? req_pc_q + 32'd4 : 32'd0;
        ib_inst1_valid_o      = keep;
        ib_inst2_valid_o      = keep && !req_slot_q;
        only_delayslot_inst_o = keep && req_slot_q;
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        slot_pending_d = slot_pending_q;
        target_d       = target_q;
        req_pc_d       = req_pc_q;
        req_slot_d     = req_slot_q;

        unique case (state_q)
            S_REQ: begin
                if (accept) begin
                    req_pc_d   = pc_q;
                    req_slot_d = slot_pending_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (icache_data_ok_i) begin
                    state_d = S_REQ;
                    if (req_slot_q) begin
                        pc_d           = target_q;
                        slot_pending_d = 1'b0;
                    end else if (bpu_taken_i && !bpu_select_i) begin
                        pc_d = bpu_target_i;
                    end else begin
                        pc_d = req_pc_q + 32'd8;
                        if (bpu_taken_i) begin
                            target_d       = bpu_target_i;
                            slot_pending_d = 1'b1;
                        end
                    end
                end
            end
            S_DISCARD: begin
                if (icache_data_ok_i) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        // A flush squashes whatever is in flight; the response is still awaited.
        if (flush_i) begin
            pc_d           = flush_pc_i;
            slot_pending_d = 1'b0;
            if (state_q == S_REQ)
                state_d = accept ? S_DISCARD : S_REQ;
            else
                state_d = icache_data_ok_i ? S_REQ : S_DISCARD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_REQ;
            pc_q           <= RESET_PC;
            slot_pending_q <= 1'b0;
            target_q       <= 32'd0;
            req_pc_q       <= 32'd0;
            req_slot_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            slot_pending_q <= slot_pending_d;
            target_q       <= target_d;
            req_pc_q       <= req_pc_d;
            req_slot_q     <= req_slot_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level fetch model.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk, rst;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        buffer_full_i;
    logic        bpu_taken_i, bpu_select_i;
    logic [31:0] bpu_target_i;
    logic        icache_req_o;
    logic [31:0] icache_addr_o;
    logic        icache_addr_ok_i, icache_data_ok_i;
    logic [31:0] icache_inst1_i, icache_inst2_i;
    logic [31:0] ib_inst1_o, ib_inst2_o, ib_inst1_addr_o, ib_inst2_addr_o;
    logic        ib_inst1_valid_o, ib_inst2_valid_o, only_delayslot_inst_o;

    int checks = 0;
    int errors = 0;

    fetch_ctrl dut (
        .clk                   (clk),
        .rst                   (rst),
        .flush_i               (flush_i),
        .flush_pc_i            (flush_pc_i),
        .buffer_full_i         (buffer_full_i),
        .bpu_taken_i           (bpu_taken_i),
        .bpu_select_i          (bpu_select_i),
        .bpu_target_i          (bpu_target_i),
        .icache_req_o          (icache_req_o),
        .icache_addr_o         (icache_addr_o),
        .icache_addr_ok_i      (icache_addr_ok_i),
        .icache_data_ok_i      (icache_data_ok_i),
        .icache_inst1_i        (icache_inst1_i),
        .icache_inst2_i        (icache_inst2_i),
        .ib_inst1_o            (ib_inst1_o),
        .ib_inst2_o            (ib_inst2_o),
        .ib_inst1_addr_o       (ib_inst1_addr_o),
        .ib_inst2_addr_o       (ib_inst2_addr_o),
        .ib_inst1_valid_o      (ib_inst1_valid_o),
        .ib_inst2_valid_o      (ib_inst2_valid_o),
        .only_delayslot_inst_o (only_delayslot_inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle;
        flush_i          = 0;
        flush_pc_i       = 0;
        buffer_full_i    = 0;
        bpu_taken_i      = 0;
        bpu_select_i     = 0;
        bpu_target_i     = 0;
        icache_addr_ok_i = 0;
        icache_data_ok_i = 0;
        icache_inst1_i   = $urandom;
        icache_inst2_i   = $urandom;
    endtask

    // Flush in REQ with no accept: next cycle fetches from a.
    task automatic redirect(input logic [31:0] a);
        @(negedge clk); idle(); flush_i = 1; flush_pc_i = a;
        @(negedge clk); idle();
    endtask

    task automatic test_reset;
        rst = 1; idle(); icache_addr_ok_i = 1;
        @(negedge clk); #1;
        checks++;
        if ({icache_req_o, icache_addr_o} !== {1'b0, RST_PC}) begin
            errors++;
            $display("FAIL reset_req got %b/%h exp 0/%h", icache_req_o, icache_addr_o, RST_PC);
        end
        checks++;
        if ({ib_inst1_valid_o, ib_inst2_valid_o, only_delayslot_inst_o, ib_inst1_o} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outs got %b%b%b %h exp zeros", ib_inst1_valid_o,
                     ib_inst2_valid_o, only_delayslot_inst_o, ib_inst1_o);
        end
        @(negedge clk); rst = 0; idle();
    endtask

    task automatic test_sequential;
        logic [31:0] a = RST_PC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); icache_addr_ok_i = 1; #1;
            checks++;
            if ({icache_req_o, icache_addr_o} !== {1'b1, a}) begin
                errors++;
                $display("FAIL seq_req%0d got %b/%h exp 1/%h", i, icache_req_o, icache_addr_o, a);
            end
            @(negedge clk); idle(); icache_data_ok_i = 1; #1;
            checks++;
            if ({ib_inst1_valid_o, ib_inst2_valid_o, only_delayslot_inst_o,
                 ib_inst1_addr_o, ib_inst2_addr_o, ib_inst1_o, ib_inst2_o} !==
                {3'b110, a, a + 32'd4, icache_inst1_i, icache_inst2_i}) begin
                errors++;
                $display("FAIL seq_data%0d got %b%b%b %h %h exp 110 %h %h", i, ib_inst1_valid_o,
                         ib_inst2_valid_o, only_delayslot_inst_o, ib_inst1_addr_o,
                         ib_inst2_addr_o, a, a + 32'd4);
            end
            a = a + 32'd8;
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] a = RST_PC + 32'd24;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idle(); buffer_full_i = 1; icache_addr_ok_i = 1; #1;
            checks++;
            if ({icache_req_o, icache_addr_o} !== {1'b0, a}) begin
                errors++;
                $display("FAIL bp_hold%0d got %b/%h exp 0/%h", i, icache_req_o, icache_addr_o, a);
            end
        end
        @(negedge clk); idle(); #1;
        checks++;
        if ({icache_req_o, icache_addr_o} !== {1'b1, a}) begin
            errors++;
            $display("FAIL bp_resume got %b/%h exp 1/%h", icache_req_o, icache_addr_o, a);
        end
    endtask

    task automatic test_branch_inst1;
        redirect(32'h100);
        @(negedge clk); idle(); icache_addr_ok_i = 1;
        @(negedge clk); idle(); icache_data_ok_i = 1;
        bpu_taken_i = 1; bpu_select_i = 0; bpu_target_i = 32'h400; #1;
        checks++;
        if ({ib_inst1_valid_o, ib_inst2_valid_o, only_delayslot_inst_o, ib_inst1_addr_o} !==
            {3'b110, 32'h100}) begin
            errors++;
            $display("FAIL br1_data got %b%b%b %h exp 110 100", ib_inst1_valid_o,
                     ib_inst2_valid_o, only_delayslot_inst_o, ib_inst1_addr_o);
        end
        @(negedge clk); idle(); icache_addr_ok_i = 1; #1;
        checks++;
        if ({icache_req_o, icache_addr_o} !== {1'b1, 32'h400}) begin
            errors++;
            $display("FAIL br1_target got %b/%h exp 1/400", icache_req_o, icache_addr_o);
        end
        @(negedge clk); idle(); icache_data_ok_i = 1;
    endtask

    task automatic test_branch_inst2;
        redirect(32'h100);
        @(negedge clk); idle(); icache_addr_ok_i = 1;
        @(negedge clk); idle(); icache_data_ok_i = 1;
        bpu_taken_i = 1; bpu_select_i = 1; bpu_target_i = 32'h400; #1;
        checks++;
        if ({ib_inst1_valid_o, ib_inst2_valid_o, only_delayslot_inst_o} !== 3'b110) begin
            errors++;
            $display("FAIL br2_pair got %b%b%b exp 110", ib_inst1_valid_o, ib_inst2_valid_o,
                     only_delayslot_inst_o);
        end
        @(negedge clk); idle(); icache_addr_ok_i = 1; #1;
        checks++;
        if ({icache_req_o, icache_addr_o} !== {1'b1, 32'h108}) begin
            errors++;
            $display("FAIL br2_slot_req got %b/%h exp 1/108", icache_req_o, icache_addr_o);
        end
        // BPU inputs on the delay-slot return must be ignored.
        @(negedge clk); idle(); icache_data_ok_i = 1;
        bpu_taken_i = 1; bpu_select_i = 0; bpu_target_i = 32'hDEAD_BEE0; #1;
        checks++;
        if ({ib_inst1_valid_o, ib_inst2_valid_o, only_delayslot_inst_o, ib_inst1_addr_o} !==
            {3'b101, 32'h108}) begin
            errors++;
            $display("FAIL br2_slot_data got %b%b%b %h exp 101 108", ib_inst1_valid_o,
                     ib_inst2_valid_o, only_delayslot_inst_o, ib_inst1_addr_o);
        end
        @(negedge clk); idle(); icache_addr_ok_i = 1; #1;
        checks++;
        if ({icache_req_o, icache_addr_o} !== {1'b1, 32'h400}) begin
            errors++;
            $display("FAIL br2_target got %b/%h exp 1/400", icache_req_o, icache_addr_o);
        end
        @(negedge clk); idle(); icache_data_ok_i = 1;
    endtask

    task automatic test_flush_wait;
        redirect(32'h200);
        @(negedge clk); idle(); icache_addr_ok_i = 1;
        @(negedge clk); idle(); flush_i = 1; flush_pc_i = 32'h800;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); icache_addr_ok_i = 1;
            icache_data_ok_i = (i == 2); #1;
            checks++;
            if ({icache_req_o, ib_inst1_valid_o, ib_inst2_valid_o} !== 3'b000) begin
                errors++;
                $display("FAIL discard%0d got req %b v %b%b exp 000", i, icache_req_o,
                         ib_inst1_valid_o, ib_inst2_valid_o);
            end
        end
        @(negedge clk); idle(); icache_addr_ok_i = 1; #1;
        checks++;
        if ({icache_req_o, icache_addr_o} !== {1'b1, 32'h800}) begin
            errors++;
            $display("FAIL discard_resume got %b/%h exp 1/800", icache_req_o, icache_addr_o);
        end
        @(negedge clk); idle(); icache_data_ok_i = 1;
    endtask

    task automatic test_flush_dataok;
        @(negedge clk); idle(); icache_addr_ok_i = 1;
        @(negedge clk); idle(); icache_data_ok_i = 1; flush_i = 1; flush_pc_i = 32'hA00; #1;
        checks++;
        if ({ib_inst1_valid_o, ib_inst2_valid_o, only_delayslot_inst_o} !== 3'b000) begin
            errors++;
            $display("FAIL flush_dok_v got %b%b%b exp 000", ib_inst1_valid_o,
                     ib_inst2_valid_o, only_delayslot_inst_o);
        end
        @(negedge clk); idle(); icache_addr_ok_i = 1; #1;
        checks++;
        if ({icache_req_o, icache_addr_o} !== {1'b1, 32'hA00}) begin
            errors++;
            $display("FAIL flush_dok_req got %b/%h exp 1/a00", icache_req_o, icache_addr_o);
        end
        @(negedge clk); idle(); icache_data_ok_i = 1;
    endtask

    task automatic test_flush_slot;
        redirect(32'h100);
        @(negedge clk); idle(); icache_addr_ok_i = 1;
        @(negedge clk); idle(); icache_data_ok_i = 1;
        bpu_taken_i = 1; bpu_select_i = 1; bpu_target_i = 32'h400;
        @(negedge clk); idle(); flush_i = 1; flush_pc_i = 32'hC00;
        @(negedge clk); idle(); icache_addr_ok_i = 1; #1;
        checks++;
        if ({icache_req_o, icache_addr_o} !== {1'b1, 32'hC00}) begin
            errors++;
            $display("FAIL slot_flush_req got %b/%h exp 1/c00", icache_req_o, icache_addr_o);
        end
        @(negedge clk); idle(); icache_data_ok_i = 1; #1;
        checks++;
        if ({ib_inst1_valid_o, ib_inst2_valid_o, only_delayslot_inst_o} !== 3'b110) begin
            errors++;
            $display("FAIL slot_flush_data got %b%b%b exp 110", ib_inst1_valid_o,
                     ib_inst2_valid_o, only_delayslot_inst_o);
        end
        @(negedge clk); idle(); #1;
        checks++;
        if (icache_addr_o !== 32'hC08) begin
            errors++;
            $display("FAIL slot_flush_next got %h exp c08", icache_addr_o);
        end
    endtask

    task automatic test_reset_midwait;
        @(negedge clk); idle(); icache_addr_ok_i = 1;
        @(negedge clk); idle(); rst = 1; icache_data_ok_i = 1; #1;
        checks++;
        if ({icache_req_o, icache_addr_o, ib_inst1_valid_o, ib_inst2_valid_o,
             only_delayslot_inst_o} !== {1'b0, RST_PC, 3'b000}) begin
            errors++;
            $display("FAIL rst_mid got %b/%h v %b%b%b exp 0/%h 000", icache_req_o,
                     icache_addr_o, ib_inst1_valid_o, ib_inst2_valid_o,
                     only_delayslot_inst_o, RST_PC);
        end
        @(negedge clk); rst = 0; idle(); icache_addr_ok_i = 1; #1;
        checks++;
        if ({icache_req_o, icache_addr_o} !== {1'b1, RST_PC}) begin
            errors++;
            $display("FAIL rst_restart got %b/%h exp 1/%h", icache_req_o, icache_addr_o, RST_PC);
        end
        @(negedge clk); idle(); icache_data_ok_i = 1;
    endtask

    // Model: next fetch address, pending delay slot, one in-flight request.
    task automatic test_random;
        logic [31:0] m_pc, m_tgt, o_pc;
        bit          m_sp, m_out, o_slot, o_sq;
        bit          er, wr, acc;
        @(negedge clk); rst = 1; idle();
        @(negedge clk); rst = 0;
        m_pc = RST_PC; m_tgt = 0; o_pc = 0;
        m_sp = 0; m_out = 0; o_slot = 0; o_sq = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            buffer_full_i    = ($urandom % 4) == 0;
            icache_addr_ok_i = $urandom % 2;
            icache_data_ok_i = m_out && (($urandom % 5) < 2);
            bpu_taken_i      = ($urandom % 3) == 0;
            bpu_select_i     = $urandom % 2;
            bpu_target_i     = $urandom & 32'hFFFF_FFFC;
            flush_i          = ($urandom % 16) == 0;
            flush_pc_i       = $urandom & 32'hFFFF_FFFC;
            icache_inst1_i   = $urandom;
            icache_inst2_i   = $urandom;
            #1;
            er  = !m_out && !buffer_full_i;
            wr  = m_out && icache_data_ok_i && !o_sq && !flush_i;
            acc = er && icache_addr_ok_i;
            checks++;
            if ({icache_req_o, icache_addr_o} !== {er, m_pc}) begin
                errors++;
                $display("FAIL rnd_req n=%0d got %b/%h exp %b/%h", n, icache_req_o,
                         icache_addr_o, er, m_pc);
            end
            checks++;
            if ({ib_inst1_valid_o, ib_inst2_valid_o, only_delayslot_inst_o} !==
                {wr, wr && !o_slot, wr && o_slot}) begin
                errors++;
                $display("FAIL rnd_valid n=%0d got %b%b%b exp %b%b%b", n, ib_inst1_valid_o,
                         ib_inst2_valid_o, only_delayslot_inst_o, wr, wr && !o_slot,
                         wr && o_slot);
            end
            if (wr) begin
                checks++;
                if ({ib_inst1_o, ib_inst2_o, ib_inst1_addr_o, ib_inst2_addr_o} !==
                    {icache_inst1_i, icache_inst2_i, o_pc, o_pc + 32'd4}) begin
                    errors++;
                    $display("FAIL rnd_data n=%0d got %h %h exp %h %h", n, ib_inst1_addr_o,
                             ib_inst2_addr_o, o_pc, o_pc + 32'd4);
                end
            end
            if (m_out && icache_data_ok_i) begin
                m_out = 0;
                if (wr) begin
                    if (o_slot) begin
                        m_pc = m_tgt; m_sp = 0;
                    end else if (bpu_taken_i && !bpu_select_i) begin
                        m_pc = bpu_target_i;
                    end else begin
                        m_pc = o_pc + 32'd8;
                        if (bpu_taken_i) begin m_tgt = bpu_target_i; m_sp = 1; end
                    end
                end
            end else if (m_out && flush_i) begin
                o_sq = 1;
            end
            if (acc) begin m_out = 1; o_pc = m_pc; o_slot = m_sp; o_sq = flush_i; end
            if (flush_i) begin m_pc = flush_pc_i; m_sp = 0; end
        end
        @(negedge clk); idle();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_inst1();
        test_branch_inst2();
        test_flush_wait();
        test_flush_dataok();
        test_flush_slot();
        test_reset_midwait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer between the PC logic, the ICache and the instruction buffer. It generates two-instruction fetch requests, honours buffer back-pressure and redirects the PC on branch-predictor hits and backend flushes. It also handles the MIPS delay slot when a predicted-taken branch sits in the second slot: it issues a single-slot fetch before jumping to the target. It produces the write-side signals of the instruction buffer (inst pair, addresses, valids, `only_delayslot_inst`).

## Interface
- `RESET_PC`, 32'hBFC0_0000: first fetch address after reset.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush_i` input 1: backend redirect; 1-cycle pulse.
- `flush_pc_i` input 32: redirect target, sampled when `flush_i`=1.
- `buffer_full_i` input 1: instruction buffer has fewer than 2 free entries.
- `bpu_taken_i` input 1: predicted-taken branch in the pair returning this cycle; valid with `icache_data_ok_i`.
- `bpu_select_i` input 1: 0 = branch is inst1, 1 = branch is inst2.
- `bpu_target_i` input 32: predicted target.
- `icache_req_o` output 1: fetch request.
- `icache_addr_o` output 32: fetch address (word aligned); inst1 = addr, inst2 = addr+4.
- `icache_addr_ok_i` input 1: request accepted this cycle.
- `icache_data_ok_i` input 1: data for the accepted request returns this cycle.
- `icache_inst1_i`, `icache_inst2_i` input 32 each: returned instructions.
- `ib_inst1_o`, `ib_inst2_o` output 32 each: instructions to the buffer.
- `ib_inst1_addr_o`, `ib_inst2_addr_o` output 32 each: their PCs.
- `ib_inst1_valid_o`, `ib_inst2_valid_o` output 1 each: write strobes.
- `only_delayslot_inst_o` output 1: only inst1 is written (delay-slot fetch).

## Operation
- State machine:
  - REQ: issue a request.
  - WAIT: accepted, data pending.
  - DISCARD: accepted request squashed by a flush.
- Registers:
  - `pc`: reset RESET_PC.
  - `slot_pending`: reset 0; the next fetch is a delay-slot-only fetch.
  - `target_q`: holds the predicted target while the delay slot is fetched.
  - `req_pc`: address of the accepted request.
  - `req_slot`: the accepted request is a delay-slot fetch.
- REQ:
  - `icache_req_o` = !`buffer_full_i`; `icache_addr_o` = `pc`.
  - On `addr_ok` (with req=1): latch `req_pc`=`pc`, `req_slot`=`slot_pending`, go to WAIT.
- WAIT, on `data_ok`:
  - Outputs (combinational, same cycle) are `ib_inst1_o`/`ib_inst2_o` = icache data, addrs = `req_pc`/`req_pc`+4, and `ib_inst1_valid_o`=1.
  - `ib_inst2_valid_o` = !`req_slot`; `only_delayslot_inst_o` = `req_slot`.
  - Next PC, first matching rule wins:
    - `req_slot`: `pc`=`target_q`, `slot_pending`=0; BPU inputs ignored.
    - taken, select=0: `pc`=`bpu_target_i` (delay slot is inst2, already fetched).
    - taken, select=1: `pc`=`req_pc`+8, `target_q`=`bpu_target_i`, `slot_pending`=1.
    - otherwise: `pc`=`req_pc`+8.
  - Then go to REQ.
- Flush in any state:
  - `pc`=`flush_pc_i`, `slot_pending`=0.
  - All `ib_*_valid_o` and `only_delayslot_inst_o` are forced 0 in that cycle.
  - REQ → REQ. The request with the old address may have been accepted (`addr_ok` the same cycle); it is then tracked as DISCARD.
  - WAIT without `data_ok` → DISCARD.
  - WAIT with `data_ok` → REQ, data dropped.
  - DISCARD → DISCARD, or → REQ if `data_ok` arrives the same cycle.
- DISCARD: `icache_req_o`=0; on `data_ok` drop the data (no valids) and go to REQ.
- Back-pressure: `buffer_full_i` only blocks new requests. Data of an accepted request is always written; the buffer's slack guarantees room.
- Adders are 32-bit and wrap modulo 2^32.
- At most one outstanding request.

## Timing
- Reset (async):
  - state REQ, `pc`=RESET_PC, `slot_pending`=0.
  - All outputs 0 except `icache_addr_o`=RESET_PC; `icache_req_o`=0 while `rst`=1.
- `icache_req_o`/`icache_addr_o` stay stable until `addr_ok`, unless a flush changes the address.
- Earliest `data_ok` is the cycle after `addr_ok`.
- Earliest next request is the cycle after `data_ok`.
- Buffer write is in the `data_ok` cycle; the new PC is visible on `icache_addr_o` one cycle later.
- Fetch rate: one pair every 2 cycles minimum.
- Flush latency: `flush_pc_i` appears on `icache_addr_o` the cycle after `flush_i` when no request is outstanding. Otherwise it appears the cycle after the squashed `data_ok`.

## Test plan
- Reset release, ICache answering `addr_ok` immediately and `data_ok` the next cycle:
  - Requests go to BFC00000, BFC00008, BFC00010.
  - Each writes two valids with addrs +0/+4.
- `buffer_full_i`=1 for 5 cycles in REQ: `icache_req_o`=0 throughout and `pc` is unchanged. Resumes the cycle after full drops.
- Taken branch in inst1, pair at 0x100, target 0x400: pair written with 2 valids; next request 0x400.
- Taken branch in inst2, pair at 0x100, target 0x400:
  - Next request is 0x108, returning with inst1 valid only and `only_delayslot_inst_o`=1, addr 0x108.
  - The request after that is 0x400.
- Flush to 0x800 in WAIT with `data_ok` 3 cycles later:
  - DISCARD state, returned data not written, no request until the drop.
  - Then request 0x800.
- Corner cases:
  - Flush in the same cycle as `data_ok`: valids 0, next request = `flush_pc_i`.
  - Flush while `slot_pending`=1: the delay-slot fetch is cancelled.
  - `rst` asserted mid-WAIT: outputs 0 immediately, restart at RESET_PC.
